simt_divergence_ctrl: RTL and testbench
=======================================

SIMT_DIVERGENCE_CTRL -- requirements
Module: simt_divergence_ctrl

Interface
REQ-001 The block SHALL have parameter WARP_SIZE, default 32, lanes per warp.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, PC width.
REQ-003 The block SHALL have parameter DEPTH, default SIMT_STACK_DEPTH, reconvergence nesting limit, matching the attached SIMT stack.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset: clk input 1 (sole clock, rising edge); rst_n input 1 (asynchronous, active-low).
REQ-005 The block SHALL have the following branch-side ports:
- br_valid input 1: branch resolved this cycle.
- br_ready output 1: branch accepted.
- br_cond input WARP_SIZE: per-lane condition.
- br_target_pc input DATA_WIDTH: taken-path PC.
- br_fall_pc input DATA_WIDTH: not-taken-path PC.
- br_reconv_pc input DATA_WIDTH: immediate post-dominator.
REQ-006 The block SHALL have the following issue-side ports:
- pc_valid input 1: issue_pc is valid.
- issue_pc input DATA_WIDTH: warp PC at issue.
- active_mask output WARP_SIZE: lanes enabled.
- redir_valid output 1: one-cycle PC redirect pulse.
- redir_pc output DATA_WIDTH: redirect PC.
- busy output 1: issue must hold.
- ovf_err output 1: sticky overflow flag.
REQ-007 The block SHALL have the following stack-side ports:
- stk_push output 1; stk_pop output 1.
- stk_push_entry output simt_stack_entry_t.
- stk_top_entry input simt_stack_entry_t.
- stk_empty input 1; stk_full input 1.
- stk_depth input $clog2(DEPTH)+1.
- stk_current_pc output DATA_WIDTH, equal to issue_pc.
- stk_at_reconv input 1.
REQ-008 The block SHALL have outputs div_count and reconv_count, each 16 bits (statistics).

Function
REQ-009 The block SHALL have states RUN and SETTLE, and SHALL keep a side table of DEPTH entries, each holding else_pc (DATA_WIDTH) and phase (1 bit).
REQ-010 reconv_hit SHALL be defined as (state==RUN) & pc_valid & ~stk_empty & stk_at_reconv.
REQ-011 br_ready SHALL be (state==RUN) & ~reconv_hit; reconvergence takes priority over a branch in the same cycle.
REQ-012 On branch acceptance the block SHALL compute T = br_cond & active_mask, where A = active_mask.
REQ-013 If T==A, the next cycle SHALL produce redir_valid=1 and redir_pc=br_target_pc, with the mask unchanged and no push.
REQ-014 If T==0, the next cycle SHALL produce redir_valid=1 and redir_pc=br_fall_pc, with the mask unchanged and no push.
REQ-015 If the branch is divergent (T≠0, T≠A) and stk_full=0, then in the same cycle:
- stk_push=1 with entry {br_reconv_pc, A, T};
- table[stk_depth] <= {br_fall_pc, 0}.
REQ-016 In the cycle after a divergent push, active_mask SHALL equal T, redir_valid=1 and redir_pc=br_target_pc.
REQ-017 If the branch is divergent and stk_full=1:
- no push;
- ovf_err SHALL be set and remain set;
- the block SHALL redirect to br_target_pc with the mask unchanged.
REQ-018 On reconv_hit with table[stk_depth-1].phase==0, the next cycle SHALL have:
- active_mask = top.active_mask & ~top.taken_mask;
- redir_valid=1 and redir_pc = table[stk_depth-1].else_pc;
- table[stk_depth-1].phase = 1.
REQ-019 On reconv_hit with phase==1, the block SHALL assert stk_pop=1 in the same cycle, and the next cycle SHALL have active_mask = top.active_mask and no redirect.
REQ-020 Every reconv_hit SHALL enter SETTLE for exactly one cycle, with busy=1 and br_ready=0, then return to RUN; this re-evaluates nested levels that share a reconvergence PC.
REQ-021 stk_push and stk_pop SHALL never be asserted together, and stk_pop SHALL never be asserted while stk_empty=1.
REQ-022 redir_valid SHALL be a registered single-cycle pulse.
REQ-023 busy SHALL be 1 exactly in SETTLE.

Reset
REQ-024 On rst_n low, regardless of any operation in progress:
- state=RUN, active_mask all ones;
- redir_valid=0, redir_pc=0, ovf_err=0;
- all table phases=0, stk_push=0, stk_pop=0;
- counters=0.
REQ-025 Reset SHALL be asynchronous assertion, synchronous deassertion; the attached stack SHALL share rst_n.

Configuration
REQ-026 With OPENGPU_DIVERGE_STATS_EN defined:
- div_count SHALL increment on each divergent push;
- reconv_count SHALL increment on each stk_pop;
- both SHALL saturate at 16'hFFFF.
REQ-027 With OPENGPU_DIVERGE_STATS_EN undefined, div_count and reconv_count SHALL be tied to 0 and no counter flops SHALL be inferred.

Verification
REQ-028 Uniform branch: mask=FFFFFFFF, br_cond=FFFFFFFF, target=0x40 -> next cycle redir_pc=0x40, no stk_push, mask=FFFFFFFF.
REQ-029 If/else divergence: br_cond=0000FFFF, target=0x100, fall=0x200, reconv=0x300.
- Expect: push {0x300, FFFFFFFF, 0000FFFF}, then mask=0000FFFF and redir 0x100.
- issue_pc=0x300 -> mask=FFFF0000, redir 0x200.
- issue_pc=0x300 again -> stk_pop, mask=FFFFFFFF.
REQ-030 Nested divergence, both levels reconverging at 0x300:
- Inner branch cond=000000FF under mask 0000FFFF.
- Expect: after both paths, two pops on successive hits separated by SETTLE; final mask=FFFFFFFF.
REQ-031 Overflow: fill to DEPTH with divergent branches, then one more divergent branch.
- Expect: no push, ovf_err=1, redir to target, mask unchanged.
REQ-032 Collision: br_valid and reconv_hit in the same cycle -> br_ready=0, reconvergence handled, branch accepted after SETTLE.
REQ-033 Reset mid-SETTLE -> all outputs at reset values, mask=FFFFFFFF.

Source files
------------

// File: rtl/simt_divergence_ctrl.sv
// simt_divergence_ctrl
//   Per-warp branch divergence / reconvergence controller. Drives an external
//   SIMT reconvergence stack and keeps a DEPTH-entry side table that remembers,
//   for each nesting level, the else-path PC and whether the else path has
//   already been launched.
//
//   Optional statistics: define OPENGPU_DIVERGE_STATS_EN to get saturating
//   div_count / reconv_count counters. Without it both outputs are tied to 0.
//
// Ports
//   clk, rst_n          sole clock (rising edge), async active-low reset
//   br_valid/br_ready   branch handshake; br_cond per-lane condition
//   br_target_pc        taken-path PC
//   br_fall_pc          not-taken-path PC
//   br_reconv_pc        reconvergence PC (immediate post-dominator)
//   pc_valid, issue_pc  current warp PC at issue
//   active_mask         enabled lanes (registered)
//   redir_valid/pc      registered one-cycle PC redirect
//   busy                issue must hold (one-cycle settle after reconvergence)
//   ovf_err             sticky stack-overflow flag
//   stk_*               stack interface; an entry is packed as
//                       {reconv_pc, active_mask, taken_mask}
//   div_count, reconv_count  16-bit statistics

`ifndef SIMT_STACK_DEPTH
`define SIMT_STACK_DEPTH 8
`endif

module simt_divergence_ctrl #(
  parameter int WARP_SIZE  = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = `SIMT_STACK_DEPTH
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                br_valid,
  output logic                                br_ready,
  input  logic [WARP_SIZE-1:0]                br_cond,
  input  logic [DATA_WIDTH-1:0]               br_target_pc,
  input  logic [DATA_WIDTH-1:0]               br_fall_pc,
  input  logic [DATA_WIDTH-1:0]               br_reconv_pc,
  input  logic                                pc_valid,
  input  logic [DATA_WIDTH-1:0]               issue_pc,
  output logic [WARP_SIZE-1:0]                active_mask,
  output logic                                redir_valid,
  output logic [DATA_WIDTH-1:0]               redir_pc,
  output logic                                busy,
  output logic                                ovf_err,
  output logic                                stk_push,
  output logic                                stk_pop,
  output logic [DATA_WIDTH+2*WARP_SIZE-1:0]   stk_push_entry,
  input  logic [DATA_WIDTH+2*WARP_SIZE-1:0]   stk_top_entry,
  input  logic                                stk_empty,
  input  logic                                stk_full,
  input  logic [$clog2(DEPTH):0]              stk_depth,
  output logic [DATA_WIDTH-1:0]               stk_current_pc,
  input  logic                                stk_at_reconv,
  output logic [15:0]                         div_count,
  output logic [15:0]                         reconv_count
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [IW:0] DEPTH_ONE = (IW+1)'(1);

  typedef enum logic {RUN, SETTLE} state_t;
  state_t state;

  logic [DATA_WIDTH-1:0] else_pc [DEPTH];
  logic [DEPTH-1:0]      phase;

  logic [DATA_WIDTH-1:0] unused_top_reconv;
  logic [WARP_SIZE-1:0]  top_active;
  logic [WARP_SIZE-1:0]  top_taken;
  logic [WARP_SIZE-1:0]  taken;
  logic [IW-1:0]         idx_push;
  logic [IW-1:0]         idx_top;
  logic                  reconv_hit;
  logic                  accept;
  logic                  divergent;

  // The controller only needs the masks of the top entry; the stack itself
  // evaluates the reconvergence PC and reports it through stk_at_reconv.
  assign {unused_top_reconv, top_active, top_taken} = stk_top_entry;

  // New level goes in at the current depth; the live level sits one below.
  assign idx_push = stk_depth[IW-1:0];
  assign idx_top  = IW'(stk_depth - DEPTH_ONE);

  assign reconv_hit = (state == RUN) & pc_valid & ~stk_empty & stk_at_reconv;
  // Reconvergence wins over a same-cycle branch, so push and pop are exclusive.
  assign br_ready   = (state == RUN) & ~reconv_hit;
  assign accept     = br_valid & br_ready;
  assign taken      = br_cond & active_mask;
  assign divergent  = (taken != '0) && (taken != active_mask);

  assign stk_push       = accept & divergent & ~stk_full;
  assign stk_pop        = reconv_hit & phase[idx_top];
  assign stk_push_entry = {br_reconv_pc, active_mask, taken};
  assign stk_current_pc = issue_pc;
  assign busy           = (state == SETTLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      active_mask <= '1;
      redir_valid <= 1'b0;
      redir_pc    <= '0;
      ovf_err     <= 1'b0;
      phase       <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        else_pc[i] <= '0;
      end
    end else begin
      redir_valid <= 1'b0;
      unique case (state)
        RUN: begin
          if (reconv_hit) begin
            // Always settle one cycle so a parent level sharing this
            // reconvergence PC is evaluated against the updated stack.
            state <= SETTLE;
            if (!phase[idx_top]) begin
              active_mask      <= top_active & ~top_taken;
              redir_valid      <= 1'b1;
              redir_pc         <= else_pc[idx_top];
              phase[idx_top]   <= 1'b1;
            end else begin
              active_mask      <= top_active;
              phase[idx_top]   <= 1'b0;
            end
          end else if (accept) begin
            redir_valid <= 1'b1;
            if (divergent && !stk_full) begin
              active_mask       <= taken;
              redir_pc          <= br_target_pc;
              else_pc[idx_push] <= br_fall_pc;
              phase[idx_push]   <= 1'b0;
            end else if (taken == '0) begin
              redir_pc <= br_fall_pc;
            end else begin
              // Uniform taken, or divergent with no room: run the taken path
              // with the full mask and flag the lost else path.
              redir_pc <= br_target_pc;
              if (divergent) begin
                ovf_err <= 1'b1;
              end
            end
          end
        end
        SETTLE: begin
          state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef OPENGPU_DIVERGE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_count    <= '0;
      reconv_count <= '0;
    end else begin
      if (stk_push && (div_count != 16'hFFFF)) begin
        div_count <= div_count + 16'd1;
      end
      if (stk_pop && (reconv_count != 16'hFFFF)) begin
        reconv_count <= reconv_count + 16'd1;
      end
    end
  end
`else
  assign div_count    = '0;
  assign reconv_count = '0;
`endif

endmodule

// File: tb/tb_simt_divergence_ctrl.sv
// Self-checking bench for simt_divergence_ctrl with a behavioural SIMT stack
// attached and a frame-list reference model of divergence/reconvergence.

module tb_simt_divergence_ctrl;

  localparam int WS    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int EW    = DW + 2*WS;
  localparam int DPW   = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          br_valid = 1'b0;
  logic          br_ready;
  logic [WS-1:0] br_cond = '0;
  logic [DW-1:0] br_target_pc = '0, br_fall_pc = '0, br_reconv_pc = '0;
  logic          pc_valid = 1'b0;
  logic [DW-1:0] issue_pc = '0;
  logic [WS-1:0] active_mask;
  logic          redir_valid;
  logic [DW-1:0] redir_pc;
  logic          busy, ovf_err, stk_push, stk_pop;
  logic [EW-1:0] stk_push_entry, stk_top_entry;
  logic          stk_empty, stk_full, stk_at_reconv;
  logic [DPW-1:0] stk_depth;
  logic [DW-1:0] stk_current_pc;
  logic [15:0]   div_count, reconv_count;

  simt_divergence_ctrl #(.WARP_SIZE(WS), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond),
    .br_target_pc(br_target_pc), .br_fall_pc(br_fall_pc), .br_reconv_pc(br_reconv_pc),
    .pc_valid(pc_valid), .issue_pc(issue_pc),
    .active_mask(active_mask), .redir_valid(redir_valid), .redir_pc(redir_pc),
    .busy(busy), .ovf_err(ovf_err),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_push_entry(stk_push_entry),
    .stk_top_entry(stk_top_entry), .stk_empty(stk_empty), .stk_full(stk_full),
    .stk_depth(stk_depth), .stk_current_pc(stk_current_pc), .stk_at_reconv(stk_at_reconv),
    .div_count(div_count), .reconv_count(reconv_count)
  );

  always #5 clk = ~clk;

  // Attached stack (shares rst_n)
  logic [EW-1:0] smem [DEPTH];
  int            scnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) scnt <= 0;
    else if (stk_push && scnt < DEPTH) begin
      smem[scnt] <= stk_push_entry;
      scnt       <= scnt + 1;
    end else if (stk_pop && scnt > 0) begin
      scnt <= scnt - 1;
    end
  end

  assign stk_empty     = (scnt == 0);
  assign stk_full      = (scnt == DEPTH);
  assign stk_depth     = DPW'(scnt);
  assign stk_top_entry = (scnt > 0) ? smem[scnt-1] : '0;
  assign stk_at_reconv = (scnt > 0) && (issue_pc == stk_top_entry[EW-1 -: DW]);

  // Reference model: list of open divergence frames
  typedef struct {
    logic [DW-1:0] reconv;
    logic [DW-1:0] else_pc;
    logic [WS-1:0] a;
    logic [WS-1:0] t;
    bit            else_done;
  } frame_t;

  frame_t        fr[$];
  logic [WS-1:0] m_mask;
  logic [DW-1:0] m_rpc;
  bit            m_rv, m_settle, m_ovf;
  int            m_div, m_rec;

  int total = 0;
  int bad   = 0;
  logic cap_ready, cap_push, cap_pop, cap_busy;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    fr.delete();
    m_mask = '1; m_rpc = '0; m_rv = 0; m_settle = 0; m_ovf = 0;
    m_div = 0; m_rec = 0;
  endtask

  function automatic logic [15:0] exp_div();
`ifdef OPENGPU_DIVERGE_STATS_EN
    return 16'(m_div);
`else
    return 16'h0;
`endif
  endfunction

  function automatic logic [15:0] exp_rec();
`ifdef OPENGPU_DIVERGE_STATS_EN
    return 16'(m_rec);
`else
    return 16'h0;
`endif
  endfunction

  // One clock: drive at posedge+1, check combinational outputs at negedge,
  // check registered outputs at the following posedge+1.
  task automatic step(input logic bv, input logic [WS-1:0] cond,
                      input logic [DW-1:0] tgt, input logic [DW-1:0] fall,
                      input logic [DW-1:0] rc, input logic pcv, input logic [DW-1:0] pc);
    bit hit, acc, dv, e_push, e_pop;
    logic [WS-1:0] t;
    int n;
    br_valid = bv; br_cond = cond; br_target_pc = tgt; br_fall_pc = fall;
    br_reconv_pc = rc; pc_valid = pcv; issue_pc = pc;
    @(negedge clk);
    n      = fr.size();
    hit    = !m_settle && pcv && (n > 0) && (pc == fr[n-1].reconv);
    acc    = bv && !m_settle && !hit;
    t      = cond & m_mask;
    dv     = (t != '0) && (t != m_mask);
    e_push = acc && dv && (n < DEPTH);
    e_pop  = hit && fr[n-1].else_done;
    cap_ready = br_ready; cap_push = stk_push; cap_pop = stk_pop; cap_busy = busy;
    chk("br_ready", br_ready, !m_settle && !hit);
    chk("stk_push", stk_push, e_push);
    chk("stk_pop", stk_pop, e_pop);
    chk("busy_comb", busy, m_settle);
    chk("stk_current_pc", stk_current_pc, pc);
    if (e_push) chk("push_entry", stk_push_entry, {rc, m_mask, t});

    m_rv = 0;
    if (m_settle) begin
      m_settle = 0;
    end else if (hit) begin
      m_settle = 1;
      if (!fr[n-1].else_done) begin
        m_mask = fr[n-1].a & ~fr[n-1].t;
        m_rv   = 1;
        m_rpc  = fr[n-1].else_pc;
        fr[n-1].else_done = 1;
      end else begin
        m_mask = fr[n-1].a;
        void'(fr.pop_back());
        if (m_rec < 65535) m_rec++;
      end
    end else if (acc) begin
      m_rv = 1;
      if (e_push) begin
        fr.push_back('{rc, fall, m_mask, t, 1'b0});
        m_mask = t;
        m_rpc  = tgt;
        if (m_div < 65535) m_div++;
      end else begin
        m_rpc = (t == '0) ? fall : tgt;
        if (dv) m_ovf = 1;
      end
    end

    @(posedge clk); #1;
    chk("active_mask", active_mask, m_mask);
    chk("redir_valid", redir_valid, m_rv);
    if (m_rv) chk("redir_pc", redir_pc, m_rpc);
    chk("ovf_err", ovf_err, m_ovf);
    chk("busy", busy, m_settle);
    chk("div_count", div_count, exp_div());
    chk("reconv_count", reconv_count, exp_rec());
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " mask"}, active_mask, {WS{1'b1}});
    chk({tag, " redir_valid"}, redir_valid, 1'b0);
    chk({tag, " redir_pc"}, redir_pc, '0);
    chk({tag, " ovf_err"}, ovf_err, 1'b0);
    chk({tag, " busy"}, busy, 1'b0);
    chk({tag, " stk_push"}, stk_push, 1'b0);
    chk({tag, " stk_pop"}, stk_pop, 1'b0);
    chk({tag, " div_count"}, div_count, 16'h0);
    chk({tag, " reconv_count"}, reconv_count, 16'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    br_valid = 1'b0; pc_valid = 1'b0; br_cond = '0; issue_pc = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic bv; logic [WS-1:0] cond; logic [DW-1:0] tgt, fall, rc;
    logic pcv; logic [DW-1:0] pc;
    logic rdy, push, pop;
    logic [WS-1:0] mask; logic rv; logic [DW-1:0] rpc;
  } vec_t;

  vec_t vt [20];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // uniform, all-not-taken, if/else divergence, nested divergence sharing 0x300
    vt[0]  = '{1'b1, 32'hFFFFFFFF, 32'h40,  32'h44,  32'h80,  1'b1, 32'h10,  1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 32'h40};
    vt[0].push = 1'b0;
    vt[1]  = '{1'b1, 32'h00000000, 32'h50,  32'h54,  32'h80,  1'b1, 32'h40,  1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1, 32'h54};
    vt[2]  = '{1'b0, 32'h0,        32'h0,   32'h0,   32'h0,   1'b1, 32'h54,  1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 32'h0};
    vt[3]  = '{1'b1, 32'h0000FFFF, 32'h100, 32'h200, 32'h300, 1'b1, 32'h60,  1'b1, 1'b1, 1'b0, 32'h0000FFFF, 1'b1, 32'h100};
    vt[4]  = '{1'b0, 32'h0,        32'h0,   32'h0,   32'h0,   1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0000FFFF, 1'b0, 32'h0};
    vt[5]  = '{1'b0, 32'h0,        32'h0,   32'h0,   32'h0,   1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 32'hFFFF0000, 1'b1, 32'h200};
    vt[6]  = '{1'b0, 32'h0,        32'h0,   32'h0,   32'h0,   1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'hFFFF0000, 1'b0, 32'h0};
    vt[7]  = '{1'b0, 32'h0,        32'h0,   32'h0,   32'h0,   1'b1, 32'h300, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h0};
    vt[8]  = '{1'b0, 32'h0,        32'h0,   32'h0,   32'h0,   1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 32'h0};
    vt[9]  = '{1'b0, 32'h0,        32'h0,   32'h0,   32'h0,   1'b1, 32'h300, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 32'h0};
    vt[10] = '{1'b1, 32'h0000FFFF, 32'h100, 32'h200, 32'h300, 1'b1, 32'h60,  1'b1, 1'b1, 1'b0, 32'h0000FFFF, 1'b1, 32'h100};
    vt[11] = '{1'b1, 32'h000000FF, 32'h180, 32'h1C0, 32'h300, 1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 32'h000000FF, 1'b1, 32'h180};
    vt[12] = '{1'b0, 32'h0,        32'h0,   32'h0,   32'h0,   1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 32'h0000FF00, 1'b1, 32'h1C0};
    vt[13] = '{1'b0, 32'h0,        32'h0,   32'h0,   32'h0,   1'b1, 32'h1C0, 1'b0, 1'b0, 1'b0, 32'h0000FF00, 1'b0, 32'h0};
    vt[14] = '{1'b0, 32'h0,        32'h0,   32'h0,   32'h0,   1'b1, 32'h300, 1'b0, 1'b0, 1'b1, 32'h0000FFFF, 1'b0, 32'h0};
    vt[15] = '{1'b0, 32'h0,        32'h0,   32'h0,   32'h0,   1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 32'h0000FFFF, 1'b0, 32'h0};
    vt[16] = '{1'b0, 32'h0,        32'h0,   32'h0,   32'h0,   1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 32'hFFFF0000, 1'b1, 32'h200};
    vt[17] = '{1'b0, 32'h0,        32'h0,   32'h0,   32'h0,   1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'hFFFF0000, 1'b0, 32'h0};
    vt[18] = '{1'b0, 32'h0,        32'h0,   32'h0,   32'h0,   1'b1, 32'h300, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h0};
    vt[19] = '{1'b0, 32'h0,        32'h0,   32'h0,   32'h0,   1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 32'h0};

    model_reset();
    do_reset();

    for (int i = 0; i < 20; i++) begin
      step(vt[i].bv, vt[i].cond, vt[i].tgt, vt[i].fall, vt[i].rc, vt[i].pcv, vt[i].pc);
      chk($sformatf("vec%0d ready", i), cap_ready, vt[i].rdy);
      chk($sformatf("vec%0d push", i), cap_push, vt[i].push);
      chk($sformatf("vec%0d pop", i), cap_pop, vt[i].pop);
      chk($sformatf("vec%0d mask", i), active_mask, vt[i].mask);
      chk($sformatf("vec%0d redir_valid", i), redir_valid, vt[i].rv);
      if (vt[i].rv) chk($sformatf("vec%0d redir_pc", i), redir_pc, vt[i].rpc);
    end

    // Overflow: fill all DEPTH levels, then one more divergent branch
    do_reset();
    begin
      logic [WS-1:0] conds [DEPTH];
      conds[0] = 32'h0000FFFF; conds[1] = 32'h000000FF;
      conds[2] = 32'h0000000F; conds[3] = 32'h00000003;
      for (int i = 0; i < DEPTH; i++) begin
        step(1'b1, conds[i], 32'h10 + 32'(i), 32'h20 + 32'(i), 32'h1000 + 32'(i*16), 1'b1, 32'h8 + 32'(i));
        chk($sformatf("ovf fill%0d push", i), cap_push, 1'b1);
      end
    end
    chk("ovf full", stk_full, 1'b1);
    step(1'b1, 32'h00000001, 32'h777, 32'h888, 32'h2000, 1'b1, 32'h30);
    chk("ovf no push", cap_push, 1'b0);
    chk("ovf flag", ovf_err, 1'b1);
    chk("ovf redir", redir_pc, 32'h777);
    chk("ovf mask", active_mask, 32'h00000003);
    step(1'b0, '0, '0, '0, '0, 1'b1, 32'h777);
    chk("ovf sticky", ovf_err, 1'b1);

    // Collision: branch presented in the same cycle as a reconvergence hit
    do_reset();
    step(1'b1, 32'h0000FFFF, 32'h100, 32'h200, 32'h300, 1'b1, 32'h60);
    step(1'b1, 32'hFFFFFFFF, 32'h500, 32'h504, 32'h600, 1'b1, 32'h300);
    chk("coll ready", cap_ready, 1'b0);
    chk("coll push", cap_push, 1'b0);
    chk("coll redir", redir_pc, 32'h200);
    chk("coll mask", active_mask, 32'hFFFF0000);
    step(1'b1, 32'hFFFFFFFF, 32'h500, 32'h504, 32'h600, 1'b1, 32'h200);
    chk("coll settle ready", cap_ready, 1'b0);
    chk("coll settle busy", cap_busy, 1'b1);
    step(1'b1, 32'hFFFFFFFF, 32'h500, 32'h504, 32'h600, 1'b1, 32'h200);
    chk("coll accept ready", cap_ready, 1'b1);
    chk("coll accept redir", redir_pc, 32'h500);

    // Reset asserted in the middle of SETTLE
    do_reset();
    step(1'b1, 32'h0000FFFF, 32'h100, 32'h200, 32'h300, 1'b1, 32'h60);
    step(1'b0, '0, '0, '0, '0, 1'b1, 32'h300);
    chk("mid settle busy", busy, 1'b1);
    br_valid = 1'b0; pc_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("mid-settle reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    step(1'b1, 32'hFFFFFFFF, 32'h40, 32'h44, 32'h80, 1'b1, 32'h10);
    chk("post reset redir", redir_pc, 32'h40);

    // Randomized traffic against the reference model
    for (int r = 0; r < 2; r++) begin
      do_reset();
      for (int i = 0; i < 150; i++) begin
        logic [WS-1:0] c;
        logic [DW-1:0] p;
        int unsigned k;
        k = $urandom_range(0, 3);
        c = (k == 0) ? '1 : (k == 1) ? '0 : $urandom;
        if (fr.size() > 0 && $urandom_range(0, 2) == 0) p = fr[fr.size()-1].reconv;
        else p = 32'($urandom_range(0, 15)) << 4;
        step(1'($urandom_range(0, 1)), c,
             32'h400 + 32'($urandom_range(0, 15)), 32'h500 + 32'($urandom_range(0, 15)),
             32'h300 + 32'($urandom_range(0, 1)) * 32'h10,
             ($urandom_range(0, 7) != 0), p);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
